iomem_bus_ctrl: RTL and testbench
=================================

# iomem_bus_ctrl

Controller for the SoC peripheral bus between the picosoc `iomem_*` master port and up to four memory-mapped peripherals (GPIO, audio, video, I2C). It decodes `addr[31:24]`, sequences each transaction to exactly one slave, and returns that slave's `ready`/`rdata` to the CPU. A bus-timeout watchdog completes hung accesses with an error pattern so the core never stalls. Unmapped regions complete immediately with zero data. `addr`, `wdata` and `wstrb` are routed to the slaves outside this block; only `valid`, `ready` and `rdata` pass through it.

## Interface
- `SEL0`, default `8'h03`: `addr[31:24]` match for slave 0 (GPIO).
- `SEL1`, default `8'h04`: match for slave 1 (audio).
- `SEL2`, default `8'h05`: match for slave 2 (video).
- `SEL3`, default `8'h07`: match for slave 3 (I2C).
- `TIMEOUT_CYCLES`, default `16'd1023`: slave cycles allowed before a forced completion; legal range 1..65535.

Ports:
- `clk  in  1`: single clock; all logic on rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `m_valid  in  1`: CPU request, held until `m_ready`.
- `m_addr  in  32`: CPU address; only `[31:24]` is used.
- `m_ready  out  1`: one-cycle completion pulse to the CPU.
- `m_rdata  out  32`: read data; valid while `m_ready`=1.
- `s_valid  out  4`: one-hot per-slave request.
- `s_ready  in  4`: per-slave completion.
- `s_rdata  in  128`: packed slave read data; slave i on `[32i+31:32i]`.
- `err_irq  out  1`: one-cycle pulse on timeout.
- `err_addr  out  32`: `m_addr` of the most recent timed-out access.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE**, `m_valid`=1:
  - If `m_addr[31:24]` equals `SELi`, latch `sel`=i, clear `cnt`, set `s_valid[i]`=1, go to ACCESS.
  - If several `SELi` match, the lowest index wins.
  - If nothing matches, set `m_ready`=1 with `m_rdata`=0 and go to DONE. This is not an error.
- **ACCESS**:
  - `s_valid[sel]` stays 1 and `cnt` increments each cycle.
  - If `s_ready[sel]`=1: `m_ready`←1, `m_rdata`←slice `sel` of `s_rdata`, `s_valid`←0, go to DONE.
  - Else if `cnt`==`TIMEOUT_CYCLES`-1: `m_ready`←1, `m_rdata`←32'hFFFF_FFFF, `s_valid`←0, `err_irq`←1, `err_addr`←`m_addr`, go to DONE.
  - If `s_ready[sel]` and timeout occur in the same cycle, the normal completion wins and no error is raised.
  - `s_ready` bits of non-selected slaves are ignored in all states.
  - If `m_valid` drops while in ACCESS (protocol violation): `s_valid`←0, go to IDLE, no `m_ready`, no error.
- **DONE**:
  - `m_ready`←0 and `err_irq`←0; `m_rdata` is held.
  - Go to IDLE unconditionally.
  - The CPU has dropped `m_valid` by this cycle, so no second transaction is started for the same request.
- `cnt` is 16 bits. Both the `cnt` comparison and `err_addr` update only in ACCESS.
- Writes and reads are sequenced identically. `m_rdata` is don't-care for writes but is still driven as specified above.

## Timing
- **Reset** (asynchronous, `resetn`=0): state=IDLE; `m_ready`, `s_valid`, `err_irq`=0; `m_rdata`, `err_addr`, `cnt`=0.
- **Reset mid-transaction**: outputs drop immediately. The transaction is lost and no `m_ready` is issued.
- **Mapped access**:
  - `m_valid` seen at edge T, so `s_valid[i]`=1 from T+1.
  - Slave asserts `ready` at edge T+k (k≥1), so `m_ready`=1 from T+k+1 for exactly one cycle.
  - Minimum latency is 2 cycles from `m_valid` to `m_ready`.
- **Unmapped access**: `m_ready`=1 at T+1.
- **Timeout**: `m_ready` and `err_irq` both assert at T+`TIMEOUT_CYCLES`+1, for one cycle each.
- **Back-to-back**: the next `m_valid` is accepted no earlier than the IDLE cycle after DONE. Minimum spacing is 3 cycles per mapped access.
- `s_valid` is never high in DONE or IDLE. At most one `s_valid` bit is high at any time.

## Test plan
- **Reset**: assert `resetn`=0 mid-ACCESS with `s_valid`=4'b0001 -> all outputs 0 on the same cycle, state IDLE after release.
- **Mapped read, immediate slave**: `m_addr`=32'h0300_0004, slave 0 ready at the first `s_valid` cycle with rdata 32'h0000_00A5 -> `m_ready` pulses 1 cycle, 2 cycles after `m_valid`, with `m_rdata`=32'h0000_00A5.
- **Slow slave, data isolation**: `m_addr`=32'h0700_0000, slave 3 ready after 5 cycles with rdata 32'h1234_5678; slave 0 holds `ready`=1 with rdata 32'hFFFF_0000 throughout -> `m_rdata`=32'h1234_5678, latency 6, only `s_valid[3]` ever high.
- **Unmapped**: `m_addr`=32'h0600_0000 -> `m_ready` at T+1, `m_rdata`=0, `s_valid`=0 throughout, `err_irq`=0.
- **Timeout**: `TIMEOUT_CYCLES`=8, `m_addr`=32'h0500_0010, slave 2 never ready -> `m_ready` and `err_irq` at T+9, `m_rdata`=32'hFFFF_FFFF, `err_addr`=32'h0500_0010.
  - Repeat with `s_ready[2]`=1 exactly on the timeout cycle -> normal completion, `err_irq`=0.
- **Back-to-back**: issue accesses to slaves 0, 1, 2, 3 consecutively, each slave immediate -> four `m_ready` pulses spaced 3 cycles apart, correct per-slave data, never two `s_valid` bits high.

Source files
------------

// File: rtl/iomem_bus_ctrl_if.sv
// Signal bundle between the picosoc iomem master port, the bus controller and up to four peripherals.
// The controller uses the slave modport; the CPU/peripheral side uses the master modport.
`timescale 1ns/1ps
interface iomem_bus_ctrl_if;
  logic         m_valid;
  logic [31:0]  m_addr;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_irq;
  logic [31:0]  err_addr;

  modport slave (
    input  m_valid, m_addr, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, err_irq, err_addr
  );

  modport master (
    output m_valid, m_addr, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, err_irq, err_addr
  );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// Peripheral bus controller: decodes addr[31:24] to one of four slaves, returns ready/rdata, times out hung slaves.
// Latency 2 cycles minimum (mapped), 1 (unmapped), TIMEOUT_CYCLES+1 on timeout; the CPU stalls on m_valid until m_ready.
`timescale 1ns/1ps
module iomem_bus_ctrl #(
  parameter logic [7:0]  SEL0           = 8'h03,
  parameter logic [7:0]  SEL1           = 8'h04,
  parameter logic [7:0]  SEL2           = 8'h05,
  parameter logic [7:0]  SEL3           = 8'h07,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
  input logic           clk,
  input logic           resetn,
  iomem_bus_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        m_ready_q, m_ready_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [3:0]  s_valid_q, s_valid_d;
  logic        err_irq_q, err_irq_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        hit;
  logic [1:0]  hit_idx;
  logic [7:0]  addr_hi;
  logic [31:0] sel_rdata;
  logic        sel_ready;
  logic        tmo;

  assign addr_hi = bus.m_addr[31:24];

  // Priority decode: lowest-index match wins when selectors overlap.
  always_comb begin
    hit     = 1'b1;
    hit_idx = 2'd0;
    if (addr_hi == SEL0) begin
      hit_idx = 2'd0;
    end else if (addr_hi == SEL1) begin
      hit_idx = 2'd1;
    end else if (addr_hi == SEL2) begin
      hit_idx = 2'd2;
    end else if (addr_hi == SEL3) begin
      hit_idx = 2'd3;
    end else begin
      hit = 1'b0;
    end
  end

  always_comb begin
    sel_rdata = 32'd0;
    case (sel_q)
      2'd0:    sel_rdata = bus.s_rdata[31:0];
      2'd1:    sel_rdata = bus.s_rdata[63:32];
      2'd2:    sel_rdata = bus.s_rdata[95:64];
      default: sel_rdata = bus.s_rdata[127:96];
    endcase
  end

  assign sel_ready = bus.s_ready[sel_q];
  assign tmo       = (cnt_q == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata_q;
    s_valid_d  = s_valid_q;
    err_irq_d  = 1'b0;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE: begin
        s_valid_d = 4'b0000;
        if (bus.m_valid) begin
          if (hit) begin
            sel_d     = hit_idx;
            cnt_d     = 16'd0;
            s_valid_d = 4'b0001 << hit_idx;
            state_d   = ACCESS;
          end else begin
            m_ready_d = 1'b1;
            m_rdata_d = 32'd0;
            state_d   = DONE;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        // A request withdrawn mid-access is dropped silently.
        if (!bus.m_valid) begin
          s_valid_d = 4'b0000;
          state_d   = IDLE;
        end else if (sel_ready) begin
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata;
          s_valid_d = 4'b0000;
          state_d   = DONE;
        end else if (tmo) begin
          m_ready_d  = 1'b1;
          m_rdata_d  = 32'hFFFF_FFFF;
          s_valid_d  = 4'b0000;
          err_irq_d  = 1'b1;
          err_addr_d = bus.m_addr;
          state_d    = DONE;
        end
      end

      DONE: begin
        s_valid_d = 4'b0000;
        state_d   = IDLE;
      end

      default: begin
        s_valid_d = 4'b0000;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      cnt_q      <= 16'd0;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= 32'd0;
      s_valid_q  <= 4'b0000;
      err_irq_q  <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      s_valid_q  <= s_valid_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.m_ready  = m_ready_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.s_valid  = s_valid_q;
  assign bus.err_irq  = err_irq_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Bench for iomem_bus_ctrl: transaction-level reference model, per-cycle output compare, directed and random traffic.
`timescale 1ns/1ps
module tb_iomem_bus_ctrl;
  localparam int TO = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  iomem_bus_ctrl_if bus();

  iomem_bus_ctrl #(.TIMEOUT_CYCLES(16'(TO))) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Current transaction plan, in posedge indices: request sampled at tx_t0, completion registered at tx_done.
  int          tx_t0    = 0;
  int          tx_done  = -1;
  int          tx_abort = -1;
  int          tx_tgt   = -1;
  logic        tx_to    = 1'b0;
  logic [31:0] tx_data  = 32'd0;
  logic [31:0] tx_addr  = 32'd0;

  logic [3:0]  exp_sv;
  logic        exp_mr;
  logic [31:0] exp_rdata    = 32'd0;
  logic [31:0] exp_err_addr = 32'd0;

  int          obs_lat;
  int          obs_cyc;
  logic [31:0] obs_rdata;
  logic        obs_irq;
  logic [31:0] obs_err_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int decode(input logic [7:0] a);
    if (a == 8'h03) return 0;
    if (a == 8'h04) return 1;
    if (a == 8'h05) return 2;
    if (a == 8'h07) return 3;
    return -1;
  endfunction

  // Per-cycle compare against the transaction plan.
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      exp_rdata    = 32'd0;
      exp_err_addr = 32'd0;
    end else begin
      exp_sv = 4'b0000;
      if (tx_tgt >= 0 && cyc >= tx_t0 && (tx_done < 0 || cyc < tx_done) &&
          (tx_abort < 0 || cyc < tx_abort))
        exp_sv[tx_tgt] = 1'b1;
      exp_mr = (tx_done >= 0) && (cyc == tx_done);
      if (exp_mr) begin
        exp_rdata = tx_data;
        if (tx_to) exp_err_addr = tx_addr;
      end
      check("s_valid",  32'(bus.s_valid), 32'(exp_sv));
      check("m_ready",  32'(bus.m_ready), 32'(exp_mr));
      check("err_irq",  32'(bus.err_irq), 32'(exp_mr && tx_to));
      check("m_rdata",  bus.m_rdata, exp_rdata);
      check("err_addr", bus.err_addr, exp_err_addr);
    end
  end

  // Called at a negedge with the controller idle; k = slave ready delay (0 = never), abort_after > 0 withdraws m_valid.
  task automatic do_txn(input logic [31:0] addr, input int k, input logic [127:0] rd,
                        input bit rnd_noise, input logic [3:0] hold, input int abort_after);
    int         tgt;
    logic [3:0] noise;
    tgt = decode(addr[31:24]);
    bus.m_addr  = addr;
    bus.s_rdata = rd;
    bus.m_valid = 1'b1;
    tx_t0    = cyc + 1;
    tx_tgt   = tgt;
    tx_addr  = addr;
    tx_to    = 1'b0;
    tx_abort = -1;
    if (tgt < 0) begin
      tx_done = tx_t0;
      tx_data = 32'd0;
    end else if (k >= 1 && k <= TO) begin
      tx_done = tx_t0 + k;
      tx_data = rd[32*tgt +: 32];
    end else begin
      tx_done = tx_t0 + TO;
      tx_data = 32'hFFFF_FFFF;
      tx_to   = 1'b1;
    end
    if (abort_after > 0) begin
      tx_abort = tx_t0 + abort_after;
      tx_done  = -1;
    end
    obs_lat = -1; obs_cyc = -1; obs_rdata = 32'd0; obs_irq = 1'b0; obs_err_addr = 32'd0;
    for (int c = 0; c < TO + 8; c++) begin
      noise = rnd_noise ? 4'($urandom()) : hold;
      if (tgt >= 0) noise[tgt] = (k >= 1) && (cyc == tx_t0 + k - 1);
      bus.s_ready = noise;
      if (tx_abort >= 0 && cyc == tx_abort - 1) bus.m_valid = 1'b0;
      @(negedge clk);
      if (bus.m_ready === 1'b1) begin
        obs_cyc      = cyc;
        obs_lat      = cyc - tx_t0 + 1;
        obs_rdata    = bus.m_rdata;
        obs_irq      = bus.err_irq;
        obs_err_addr = bus.err_addr;
        break;
      end
      if (tx_abort >= 0 && cyc >= tx_abort + 1) break;
    end
    bus.m_valid = 1'b0;
    bus.s_ready = rnd_noise ? 4'($urandom()) : hold;
    if (tx_abort < 0) begin
      n_cmp++;
      if (obs_lat < 0) begin
        n_bad++;
        $display("FAIL completion: no m_ready for addr %h, required one within %0d cycles", addr, TO + 8);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000 ns");
    $fatal(1);
  end

  initial begin
    int          prev;
    logic [7:0]  hi;
    logic [127:0] rd;
    bus.m_valid = 1'b0;
    bus.m_addr  = 32'd0;
    bus.s_ready = 4'b0000;
    bus.s_rdata = 128'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst m_ready",  32'(bus.m_ready), 32'd0);
    check("rst s_valid",  32'(bus.s_valid), 32'd0);
    check("rst err_irq",  32'(bus.err_irq), 32'd0);
    check("rst m_rdata",  bus.m_rdata, 32'd0);
    check("rst err_addr", bus.err_addr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Immediate slave 0
    do_txn(32'h0300_0004, 1, {96'd0, 32'h0000_00A5}, 1'b0, 4'b0000, 0);
    check("imm latency", 32'(obs_lat), 32'd2);
    check("imm rdata",   obs_rdata, 32'h0000_00A5);
    check("imm irq",     32'(obs_irq), 32'd0);

    // Slow slave 3 while slave 0 holds ready with other data
    do_txn(32'h0700_0000, 5, {32'h1234_5678, 64'd0, 32'hFFFF_0000}, 1'b0, 4'b0001, 0);
    check("slow latency", 32'(obs_lat), 32'd6);
    check("slow rdata",   obs_rdata, 32'h1234_5678);

    // Unmapped region
    do_txn(32'h0600_0000, 1, {4{32'hDEAD_BEEF}}, 1'b0, 4'b1111, 0);
    check("unmap latency", 32'(obs_lat), 32'd1);
    check("unmap rdata",   obs_rdata, 32'd0);
    check("unmap irq",     32'(obs_irq), 32'd0);

    // Timeout on slave 2
    do_txn(32'h0500_0010, 0, {4{32'h5555_AAAA}}, 1'b0, 4'b0000, 0);
    check("tmo latency",  32'(obs_lat), 32'd9);
    check("tmo rdata",    obs_rdata, 32'hFFFF_FFFF);
    check("tmo irq",      32'(obs_irq), 32'd1);
    check("tmo err_addr", obs_err_addr, 32'h0500_0010);

    // Ready exactly on the timeout cycle: normal completion wins
    do_txn(32'h0500_0020, TO, {32'd0, 32'hCAFE_F00D, 64'd0}, 1'b0, 4'b0000, 0);
    check("edge latency",  32'(obs_lat), 32'd9);
    check("edge rdata",    obs_rdata, 32'hCAFE_F00D);
    check("edge irq",      32'(obs_irq), 32'd0);
    check("edge err_addr", obs_err_addr, 32'h0500_0010);

    // Request withdrawn mid-access, then a normal access
    do_txn(32'h0400_0000, 0, {4{32'h0BAD_0BAD}}, 1'b0, 4'b0000, 3);
    do_txn(32'h0400_0008, 1, {64'd0, 32'h0000_0042, 32'd0}, 1'b0, 4'b0000, 0);
    check("post-abort latency", 32'(obs_lat), 32'd2);
    check("post-abort rdata",   obs_rdata, 32'h0000_0042);

    // Back-to-back to slaves 0..3
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      hi = (i == 3) ? 8'h07 : 8'(8'h03 + i);
      do_txn({hi, 24'h000100}, 1, {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000}, 1'b1, 4'b0000, 0);
      check("b2b rdata", obs_rdata, 32'((i * 32'h1111_0001) & 32'hFFFF_000F));
      if (prev >= 0) check("b2b spacing", 32'(obs_cyc - prev), 32'd3);
      prev = obs_cyc;
    end

    // Asynchronous reset mid-access
    bus.m_addr  = 32'h0300_0000;
    bus.s_ready = 4'b0000;
    bus.m_valid = 1'b1;
    tx_t0 = cyc + 1; tx_tgt = 0; tx_addr = 32'h0300_0000; tx_to = 1'b1;
    tx_abort = -1; tx_done = tx_t0 + TO; tx_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("pre-reset s_valid", 32'(bus.s_valid), 32'b0001);
    resetn = 1'b0;
    tx_tgt = -1; tx_done = -1;
    #1;
    check("arst m_ready",  32'(bus.m_ready), 32'd0);
    check("arst s_valid",  32'(bus.s_valid), 32'd0);
    check("arst err_irq",  32'(bus.err_irq), 32'd0);
    check("arst m_rdata",  bus.m_rdata, 32'd0);
    check("arst err_addr", bus.err_addr, 32'd0);
    bus.m_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_txn(32'h0300_0000, 2, {96'd0, 32'h0000_7777}, 1'b1, 4'b0000, 0);
    check("post-reset latency", 32'(obs_lat), 32'd3);
    check("post-reset rdata",   obs_rdata, 32'h0000_7777);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: hi = 8'h03;
        1: hi = 8'h04;
        2: hi = 8'h05;
        3: hi = 8'h07;
        4: hi = 8'h06;
        default: hi = 8'($urandom());
      endcase
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_txn({hi, 24'($urandom())}, int'($urandom_range(0, TO + 2)), rd, 1'b1, 4'b0000, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
